// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Segment patterns are active-low, bit order g..a (bit 6 = g, bit 0 = a).
package seg7_pkg;

   localparam logic [6:0] SEG_HEX_0 = 7'h40;
   localparam logic [6:0] SEG_HEX_1 = 7'h79;
   localparam logic [6:0] SEG_HEX_2 = 7'h24;
   localparam logic [6:0] SEG_HEX_3 = 7'h30;
   localparam logic [6:0] SEG_HEX_4 = 7'h19;
   localparam logic [6:0] SEG_HEX_5 = 7'h12;
   localparam logic [6:0] SEG_HEX_6 = 7'h02;
   localparam logic [6:0] SEG_HEX_7 = 7'h78;
   localparam logic [6:0] SEG_HEX_8 = 7'h00;
   localparam logic [6:0] SEG_HEX_9 = 7'h10;
   localparam logic [6:0] SEG_HEX_A = 7'h08;
   localparam logic [6:0] SEG_HEX_B = 7'h03;
   localparam logic [6:0] SEG_HEX_C = 7'h46;
   localparam logic [6:0] SEG_HEX_D = 7'h21;
   localparam logic [6:0] SEG_HEX_E = 7'h06;
   localparam logic [6:0] SEG_HEX_F = 7'h0E;

   // Full cathode pattern with every segment and the decimal point dark.
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Blink phase of the whole display.
   typedef enum logic {
      PHASE_OFF = 1'b0,
      PHASE_ON  = 1'b1
   } blink_phase_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern (g..a).
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Table lookup of the sixteen hex glyphs.
   always_comb begin
      seg = SEG_HEX_0;
      case (nibble)
         4'h0: seg = SEG_HEX_0;
         4'h1: seg = SEG_HEX_1;
         4'h2: seg = SEG_HEX_2;
         4'h3: seg = SEG_HEX_3;
         4'h4: seg = SEG_HEX_4;
         4'h5: seg = SEG_HEX_5;
         4'h6: seg = SEG_HEX_6;
         4'h7: seg = SEG_HEX_7;
         4'h8: seg = SEG_HEX_8;
         4'h9: seg = SEG_HEX_9;
         4'hA: seg = SEG_HEX_A;
         4'hB: seg = SEG_HEX_B;
         4'hC: seg = SEG_HEX_C;
         4'hD: seg = SEG_HEX_D;
         4'hE: seg = SEG_HEX_E;
         4'hF: seg = SEG_HEX_F;
         default: seg = SEG_HEX_0;
      endcase
   end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed seven-segment display scanner.
// A prescaler divides clk into digit slots; the digit index walks the slots
// and its wrap marks a frame boundary. New data is staged in a shadow
// register and only copied to the displayed (active) register at a frame
// boundary so a frame never mixes old and new digits. Anode/cathode outputs
// are registered one cycle behind the prescaler/index state.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int DIGITS       = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int DEADTIME     = 2,
   parameter int BLINK_FRAMES = 32
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  load,
   input  logic                  blank_lz,
   input  logic                  blink_en,
   output logic [DIGITS-1:0]     an,
   output logic [7:0]            ca,
   output logic                  frame_done
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] DEAD_CNT   = PW'(DEADTIME);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [PW-1:0]          presc_reg;
   logic [IW-1:0]          idx_reg;
   logic                   tick;
   logic                   boundary;

   logic [4*DIGITS-1:0]    active_value_reg;
   logic [DIGITS-1:0]      active_dp_reg;
   logic [4*DIGITS-1:0]    shadow_value_reg;
   logic [DIGITS-1:0]      shadow_dp_reg;
   logic                   pending_reg;

   logic [BW-1:0]          blink_cnt_reg;
   blink_phase_t           phase_reg;

   logic                   frame_done_reg;
   logic [DIGITS-1:0]      an_reg;
   logic [7:0]             ca_reg;
   logic [DIGITS-1:0]      an_next;
   logic [7:0]             ca_next;

   logic [3:0]             nib [DIGITS];
   logic [DIGITS-1:0]      lz_blank;
   logic [3:0]             cur_nib;
   logic [6:0]             cur_seg;

   assign tick     = (presc_reg == PRESC_LAST);
   assign boundary = tick && (idx_reg == IDX_LAST);

   // Per-digit nibble view and leading-zero flags: digit i is a leading zero
   // when it and every digit to its left are zero; digit 0 always shows.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign nib[gi] = active_value_reg[4*gi +: 4];
         if (gi == 0) begin : g_lsd
            assign lz_blank[gi] = 1'b0;
         end else begin : g_upper
            assign lz_blank[gi] = ~|active_value_reg[4*DIGITS-1:4*gi];
         end
      end
   endgenerate

   assign cur_nib = nib[idx_reg];

   seg7_hex_decode u_decode (
      .nibble (cur_nib),
      .seg    (cur_seg)
   );

   // Slot prescaler and digit index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_reg <= '0;
         idx_reg   <= '0;
      end else if (tick) begin
         presc_reg <= '0;
         idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
      end else begin
         presc_reg <= presc_reg + PW'(1);
      end
   end

   // Shadow capture on load; tear-free transfer to active at frame boundary.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_value_reg <= '0;
         active_dp_reg    <= '0;
         shadow_value_reg <= '0;
         shadow_dp_reg    <= '0;
         pending_reg      <= 1'b0;
      end else begin
         if (load) begin
            shadow_value_reg <= value;
            shadow_dp_reg    <= dp;
         end
         if (boundary) begin
            if (load) begin
               active_value_reg <= value;
               active_dp_reg    <= dp;
            end else if (pending_reg) begin
               active_value_reg <= shadow_value_reg;
               active_dp_reg    <= shadow_dp_reg;
            end
            pending_reg <= 1'b0;
         end else if (load) begin
            pending_reg <= 1'b1;
         end
      end
   end

   // Blink phase toggles every BLINK_FRAMES frames while enabled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink_cnt_reg <= '0;
         phase_reg     <= PHASE_ON;
      end else if (!blink_en) begin
         blink_cnt_reg <= '0;
         phase_reg     <= PHASE_ON;
      end else if (boundary) begin
         if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            phase_reg     <= (phase_reg == PHASE_ON) ? PHASE_OFF : PHASE_ON;
         end else begin
            blink_cnt_reg <= blink_cnt_reg + BW'(1);
         end
      end
   end

   // Next anode/cathode pattern for the current slot.
   always_comb begin
      an_next = ~(DIGITS'(1) << idx_reg);
      ca_next = {~active_dp_reg[idx_reg], cur_seg};
      if ((phase_reg == PHASE_OFF) || (blank_lz && lz_blank[idx_reg])) begin
         an_next = '1;
         ca_next = SEG_BLANK;
      end else if (presc_reg < DEAD_CNT) begin
         an_next = '1;
      end
   end

   // Registered outputs and frame pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an_reg         <= '1;
         ca_reg         <= SEG_BLANK;
         frame_done_reg <= 1'b0;
      end else begin
         an_reg         <= an_next;
         ca_reg         <= ca_next;
         frame_done_reg <= boundary;
      end
   end

   assign an         = an_reg;
   assign ca         = ca_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (>=2).
REQ-003 SHALL have parameter DEADTIME, default 2, cycles per slot with all anodes off (0..REFRESH_DIV-1).
REQ-004 SHALL have parameter BLINK_FRAMES, default 32, frames per blink half-period (>=1).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port value  input  4*DIGITS  hex nibbles; nibble i drives digit i (0 = rightmost).
REQ-008 SHALL have port dp  input  DIGITS  decimal-point enable per digit, active-high.
REQ-009 SHALL have port load  input  1  single-cycle strobe capturing value and dp.
REQ-010 SHALL have port blank_lz  input  1  leading-zero blanking mode.
REQ-011 SHALL have port blink_en  input  1  whole-display blink mode.
REQ-012 SHALL have port an  output  DIGITS  anode selects, active-low.
REQ-013 SHALL have port ca  output  8  cathodes, active-low; ca[7]=dp, ca[6:0]=g..a.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-015 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; terminal count is a slot tick.
REQ-016 Digit index SHALL advance on each tick, wrapping DIGITS-1 -> 0; that wrap is a frame boundary.
REQ-017 frame_done SHALL pulse high for exactly one cycle, registered, in the cycle after the frame-boundary tick.
REQ-018 load SHALL capture value/dp into a shadow register and set pending; active register SHALL update only at a frame boundary (no tearing).
REQ-019 At a frame boundary: load high -> active takes inputs directly; else pending -> active takes shadow; pending clears either way.
REQ-020 Repeated loads before a boundary SHALL keep only the last one.
REQ-021 an SHALL be all-ones while prescaler < DEADTIME; otherwise only bit[index] low.
REQ-022 ca SHALL be the hex decode of active nibble[index], ca[7] = ~dp[index]; 0->8'hC0, 1->8'hF9, 4->8'h99, 5->8'h92, 8->8'h80, F->8'h8E.
REQ-023 blank_lz high: digit i>0 SHALL be blanked (anode off, ca=8'hFF) when active nibbles i..DIGITS-1 are all zero; digit 0 never blanked.
REQ-024 blink_en high: frame counter SHALL toggle a phase every BLINK_FRAMES frames; during off phase an all-ones, ca=8'hFF; blink_en low forces on phase and clears the counter.
REQ-025 an and ca SHALL be registered: one cycle latency from prescaler/index state.
REQ-026 DIGITS=1 SHALL produce a frame boundary on every tick.

Reset
REQ-027 reset low SHALL immediately set an all-ones, ca=8'hFF, frame_done=0.
REQ-028 reset low SHALL clear prescaler, index, active, shadow, pending, blink counter; blink phase = on.
REQ-029 Reset mid-frame SHALL discard pending loads; scan restarts at digit 0, prescaler 0, after release.

Structure
REQ-030 Package seg7_pkg SHALL hold the 16 hex segment constants and SEG_BLANK=8'hFF.
REQ-031 Hex-to-segment decode SHALL be sub-module seg7_hex_decode (combinational, 4-bit in, 7-bit out).

Verification (DIGITS=4, REFRESH_DIV=4, DEADTIME=1, BLINK_FRAMES=2)
REQ-032 Hold reset low 3 cycles -> an=4'b1111, ca=8'hFF throughout; after release, first an=4'b1110 on 2nd registered cycle.
REQ-033 load value=16'h1234, dp=0 -> after next frame_done, slot0 ca=8'h99, slot3 ca=8'hF9, an walks 1110,1101,1011,0111.
REQ-034 load 16'h00AB mid-frame -> old data until frame_done; then new; load coincident with boundary tick -> shown in the following frame's slot0.
REQ-035 blank_lz=1, value=16'h0005 -> slots 1-3 an=4'b1111, ca=8'hFF; slot0 ca=8'h92; value=16'h0000 -> slot0 shows ca=8'hC0.
REQ-036 blink_en=1 -> 2 frames visible, 2 frames an=4'b1111, repeating; dp=4'b0001 -> slot0 ca[7]=0.
REQ-037 reset low mid slot2 with pending load -> outputs blank at once; after release old and pending data absent (digits show 0).
